// File: rtl/occupancy_band_ctrl.sv
// Occupancy counter with four-band bulb/temperature classification and a saturating energy total.
// Build option: define OCC_BAND_HOLD_EN to debounce band changes for HOLD_CYCLES (red is never delayed).
module occupancy_band_ctrl #(
    parameter int CNT_W       = 4,
    parameter int ENERGY_W    = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc_enable,
    input  logic                dec_enable,
    input  logic [CNT_W-1:0]    max_value,
    input  logic                tick,
    input  logic                bill_clear,
    output logic [CNT_W-1:0]    count,
    output logic [1:0]          bulbs,
    output logic [4:0]          temperature,
    output logic [ENERGY_W-1:0] energy,
    output logic                full,
    output logic                empty,
    output logic                overflow_evt,
    output logic                underflow_evt
);

    typedef enum logic [1:0] {
        BAND_GREEN  = 2'b00,
        BAND_BLUE   = 2'b01,
        BAND_YELLOW = 2'b10,
        BAND_RED    = 2'b11
    } band_t;

    localparam int BW = CNT_W + 2;

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_hold_range
            $error("HOLD_CYCLES must be in 1..255");
        end
    endgenerate

    function automatic logic [4:0] band_temp(input logic [1:0] band);
        case (band)
            2'b00:   band_temp = 5'd28;
            2'b01:   band_temp = 5'd24;
            2'b10:   band_temp = 5'd20;
            default: band_temp = 5'd16;
        endcase
    endfunction

    logic [BW-1:0]     count_x4;
    logic [BW-1:0]     max_x1;
    logic [BW-1:0]     max_x2;
    band_t             raw_band;
    logic [ENERGY_W:0] energy_sum;

    assign full  = (count == max_value);
    assign empty = (count == '0);

    // Quarter/half thresholds compared as 4*count against max and 2*max, avoiding a divider.
    always_comb begin
        count_x4 = {count, 2'b00};
        max_x1   = {2'b00, max_value};
        max_x2   = {1'b0, max_value, 1'b0};
        if (count == max_value)
            raw_band = BAND_RED;
        else if (count_x4 <= max_x1)
            raw_band = BAND_GREEN;
        else if (count_x4 <= max_x2)
            raw_band = BAND_BLUE;
        else
            raw_band = BAND_YELLOW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            overflow_evt  <= 1'b0;
            underflow_evt <= 1'b0;
        end else begin
            overflow_evt  <= 1'b0;
            underflow_evt <= 1'b0;
            if (count > max_value) begin
                count <= max_value;
            end else if (inc_enable && dec_enable) begin
                count <= count;
            end else if (inc_enable) begin
                if (count < max_value)
                    count <= count + 1'b1;
                else
                    overflow_evt <= 1'b1;
            end else if (dec_enable) begin
                if (count != '0)
                    count <= count - 1'b1;
                else
                    underflow_evt <= 1'b1;
            end
        end
    end

    assign energy_sum = {1'b0, energy} + {{(ENERGY_W-1){1'b0}}, bulbs};

    always_ff @(posedge clk) begin
        if (reset || bill_clear)
            energy <= '0;
        else if (tick)
            energy <= energy_sum[ENERGY_W] ? {ENERGY_W{1'b1}} : energy_sum[ENERGY_W-1:0];
    end

`ifdef OCC_BAND_HOLD_EN
    logic [1:0] cand;
    logic [7:0] hold_cnt;
    logic [8:0] hold_next;

    // A run restarts at 1 whenever the candidate changes or the counter was idle.
    always_comb begin
        if (raw_band == cand && hold_cnt != 8'd0)
            hold_next = {1'b0, hold_cnt} + 9'd1;
        else
            hold_next = 9'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bulbs       <= BAND_GREEN;
            temperature <= 5'd28;
            cand        <= BAND_GREEN;
            hold_cnt    <= 8'd0;
        end else if (raw_band == BAND_RED) begin
            bulbs       <= BAND_RED;
            temperature <= 5'd16;
            cand        <= BAND_RED;
            hold_cnt    <= 8'd0;
        end else if (raw_band == bulbs) begin
            hold_cnt    <= 8'd0;
        end else if (hold_next >= 9'(HOLD_CYCLES)) begin
            bulbs       <= raw_band;
            temperature <= band_temp(raw_band);
            cand        <= raw_band;
            hold_cnt    <= 8'd0;
        end else begin
            cand        <= raw_band;
            hold_cnt    <= hold_next[7:0];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            bulbs       <= BAND_GREEN;
            temperature <= 5'd28;
        end else begin
            bulbs       <= raw_band;
            temperature <= band_temp(raw_band);
        end
    end
`endif

endmodule

// File: doc/occupancy_band_ctrl.md
# occupancy_band_ctrl

Parametrised room-occupancy controller. It keeps a saturating up/down occupancy count against a run-time maximum and classifies occupancy into four bands: green, blue, yellow and red. Each band drives a bulb code and an HVAC temperature setpoint. The block also accumulates a saturating energy total on an external sample strobe. It sits between the door-sensor pulse logic and the lighting/HVAC/billing outputs, and supersedes the fixed 4-bit single-mode counter.

## Interface
- CNT_W, 4: width of the occupancy count and of max_value.
- ENERGY_W, 8: width of the energy accumulator.
- HOLD_CYCLES, 4: consecutive cycles a new band must persist before it is adopted. Used only with OCC_BAND_HOLD_EN. Legal range is 1..255.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inc_enable  in  1  one person entered (level, sampled each cycle).
- dec_enable  in  1  one person left.
- max_value  in  CNT_W  room capacity; may change at any time.
- tick  in  1  energy sample strobe.
- bill_clear  in  1  clears the energy accumulator.
- count  out  CNT_W  registered occupancy.
- bulbs  out  2  registered band: 00 green, 01 blue, 10 yellow, 11 red.
- temperature  out  5  registered setpoint for the current bulbs value.
- energy  out  ENERGY_W  registered, saturating energy total.
- full  out  1  count == max_value (combinational from count register).
- empty  out  1  count == 0 (combinational).
- overflow_evt  out  1  one-cycle pulse: increment rejected at full.
- underflow_evt  out  1  one-cycle pulse: decrement rejected at empty.

## Operation
- **Count update**, evaluated in priority order each cycle:
  - reset: count = 0.
  - count > max_value (capacity lowered): count = max_value, and inc/dec are ignored that cycle.
  - inc_enable and dec_enable both high: count unchanged, no event pulses.
  - inc_enable only: count + 1 if count < max_value; otherwise overflow_evt = 1 for that cycle.
  - dec_enable only: count − 1 if count > 0; otherwise underflow_evt = 1 for that cycle.
- **Raw band**, computed from the count register without a divider. Intermediates are CNT_W+2 bits. First match wins:
  - count == max_value → 11 (red).
  - 4·count ≤ max_value → 00 (green).
  - 4·count ≤ 2·max_value → 01 (blue).
  - otherwise → 10 (yellow).
- max_value = 0 gives count 0 == max, so the raw band is red and full = empty = 1.
- **Temperature** is set by the bulbs value: 00 → 28, 01 → 24, 10 → 20, 11 → 16. It is registered together with bulbs.
- **Energy**, evaluated in priority order each cycle:
  - bill_clear: energy = 0. It wins over a simultaneous tick, and that tick is lost.
  - tick: energy = min(energy + bulbs, 2^ENERGY_W − 1), where bulbs is the registered value before the edge.
  - Energy saturates at the maximum and never wraps.
- **Reset values:** count 0, bulbs 00, temperature 28, energy 0, overflow_evt 0, underflow_evt 0. This gives full 0 for max_value > 0, and empty 1.

## Timing
- count changes on the edge that samples inc_enable or dec_enable.
- bulbs and temperature follow the raw band one cycle later, i.e. two edges after the input is sampled (no-hold build).
- Event pulses are registered and high in the cycle after the edge that sampled the rejected request.
- energy reflects a tick on the edge that samples it.
- Reset mid-operation clears all state on the next edge, including the hold counter and the candidate band.

## Configuration
- **OCC_BAND_HOLD_EN defined:** adds a band debounce.
  - A candidate register and a hold counter track the raw band.
  - When the raw band differs from bulbs, it becomes the candidate.
  - Each consecutive cycle in which the raw band equals the candidate increments the hold counter.
  - When the counter reaches HOLD_CYCLES, bulbs and temperature update to the candidate and the counter clears.
  - Any change in the raw band restarts the count at 1.
  - If the raw band returns to the current bulbs value, the counter clears with no update.
  - Exception: a raw band of red (11) is adopted on the next edge with no hold.
- **OCC_BAND_HOLD_EN undefined:** bulbs = raw band, registered every cycle. HOLD_CYCLES is unused and no hold logic is generated.

## Test plan
- **Reset and basic bands:** reset, max_value = 8, four single-cycle inc pulses.
  - count 1..4; bulbs 00 at count 2 (8 ≤ 8).
  - bulbs 01 at count 3 and 4.
  - count 5 → bulbs 10, temperature 20.
- **Full, overflow, simultaneous requests:** max_value = 8, raise count to 8.
  - bulbs 11, temperature 16, full = 1.
  - A further inc → count stays 8 and overflow_evt pulses for one cycle.
  - inc and dec together → count stays 8 and no pulse.
- **Empty and underflow:** from count 0, dec → count 0, underflow_evt = 1 for one cycle, empty = 1.
- **Capacity shrink:** count 6 with max_value 8, then set max_value = 3.
  - count = 3 next edge; bulbs 11 one edge later.
  - An inc in the shrink cycle is ignored.
- **Energy:** bulbs held at 10 with ENERGY_W = 8.
  - 200 ticks → energy saturates at 255.
  - bill_clear together with tick → energy 0.
- **Hold (OCC_BAND_HOLD_EN, HOLD_CYCLES = 4):**
  - A green→blue raw change lasting 3 cycles leaves bulbs at 00.
  - Lasting 4 cycles → bulbs 01.
  - A jump to full → bulbs 11 after one edge.
